// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the EXE-stage multiply/divide unit: op codes and FSM states.
package mul_div_unit_pkg;

   localparam int MD_OP_LEN = 2;

   localparam logic [MD_OP_LEN-1:0] MD_MULTU = 2'b00;
   localparam logic [MD_OP_LEN-1:0] MD_MULT  = 2'b01;
   localparam logic [MD_OP_LEN-1:0] MD_DIVU  = 2'b10;
   localparam logic [MD_OP_LEN-1:0] MD_DIV   = 2'b11;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIX  = 2'd2
   } md_state_e;

endpackage

// File: rtl/mul_div_unit_sign_adjust.sv
// Sign fixup for magnitude results: negates the 2W-bit product for multiplies,
// or the quotient and remainder independently for divides.
module md_sign_adjust #(
   parameter int WORD_LEN = 32
) (
   input  logic                is_div_i,
   input  logic [WORD_LEN-1:0] mag_hi_i,
   input  logic [WORD_LEN-1:0] mag_lo_i,
   input  logic                neg_q_i,
   input  logic                neg_r_i,
   output logic [WORD_LEN-1:0] hi_o,
   output logic [WORD_LEN-1:0] lo_o
);

   logic [2*WORD_LEN-1:0] prod;
   logic [2*WORD_LEN-1:0] prod_neg;

   // Select between full-width product negation and per-half quotient/remainder negation.
   always_comb begin
      prod     = {mag_hi_i, mag_lo_i};
      prod_neg = -prod;
      hi_o     = mag_hi_i;
      lo_o     = mag_lo_i;
      if (is_div_i) begin
         if (neg_r_i) hi_o = -mag_hi_i;
         if (neg_q_i) lo_o = -mag_lo_i;
      end else if (neg_q_i) begin
         hi_o = prod_neg[2*WORD_LEN-1:WORD_LEN];
         lo_o = prod_neg[WORD_LEN-1:0];
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider producing HI/LO.
// One bit per cycle on magnitudes; signs are restored in a final FIX cycle.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WORD_LEN = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [MD_OP_LEN-1:0] md_op,
   input  logic [WORD_LEN-1:0]  val1,
   input  logic [WORD_LEN-1:0]  val2,
   input  logic                 flush,
   output logic                 busy,
   output logic                 done,
   output logic                 div_by_zero,
   output logic [WORD_LEN-1:0]  hi,
   output logic [WORD_LEN-1:0]  lo
);

   localparam int CNT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_LEN - 1);

   md_state_e             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   // Multiply: {partial product, remaining multiplier}. Divide: low half is dividend/quotient.
   logic [2*WORD_LEN-1:0] acc_q, acc_d;
   logic [WORD_LEN:0]     rem_q, rem_d;
   logic [WORD_LEN-1:0]   op2_q, op2_d;
   logic                  div_q, div_d;
   logic                  negq_q, negq_d;
   logic                  negr_q, negr_d;
   logic                  dbz_q, dbz_d;
   logic [WORD_LEN-1:0]   hi_q, hi_d;
   logic [WORD_LEN-1:0]   lo_q, lo_d;
   logic                  done_q, done_d;
   logic                  dbz_out_q, dbz_out_d;

   logic                  op_is_div, op_is_signed, sign1, sign2;
   logic [WORD_LEN-1:0]   abs1, abs2;
   logic [WORD_LEN:0]     mul_sum;
   logic [WORD_LEN:0]     div_shift;
   logic [WORD_LEN+1:0]   div_diff;
   logic [WORD_LEN-1:0]   adj_hi, adj_lo;

   md_sign_adjust #(.WORD_LEN(WORD_LEN)) u_sign_adjust (
      .is_div_i (div_q),
      .mag_hi_i (div_q ? rem_q[WORD_LEN-1:0] : acc_q[2*WORD_LEN-1:WORD_LEN]),
      .mag_lo_i (acc_q[WORD_LEN-1:0]),
      .neg_q_i  (negq_q),
      .neg_r_i  (negr_q),
      .hi_o     (adj_hi),
      .lo_o     (adj_lo)
   );

   // State and working registers; everything clears on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= MD_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         rem_q     <= '0;
         op2_q     <= '0;
         div_q     <= 1'b0;
         negq_q    <= 1'b0;
         negr_q    <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dbz_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         op2_q     <= op2_d;
         div_q     <= div_d;
         negq_q    <= negq_d;
         negr_q    <= negr_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dbz_out_q <= dbz_out_d;
      end
   end

   // Next-state logic: operand capture, one iteration per RUN cycle, sign fixup in FIX.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      op2_d     = op2_q;
      div_d     = div_q;
      negq_d    = negq_q;
      negr_d    = negr_q;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dbz_out_d = 1'b0;

      op_is_div    = (md_op == MD_DIVU) || (md_op == MD_DIV);
      op_is_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
      sign1        = op_is_signed & val1[WORD_LEN-1];
      sign2        = op_is_signed & val2[WORD_LEN-1];
      abs1         = sign1 ? -val1 : val1;
      abs2         = sign2 ? -val2 : val2;

      mul_sum   = {1'b0, acc_q[2*WORD_LEN-1:WORD_LEN]} + {1'b0, (acc_q[0] ? op2_q : '0)};
      div_shift = {rem_q[WORD_LEN-1:0], acc_q[WORD_LEN-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, op2_q};

      if (flush) begin
         // Abort: drop the operation, leave hi/lo untouched, no done.
         state_d = MD_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            MD_IDLE: begin
               if (start) begin
                  div_d  = op_is_div;
                  cnt_d  = '0;
                  rem_d  = '0;
                  op2_d  = abs2;
                  negq_d = sign1 ^ sign2;
                  negr_d = sign1;
                  if (op_is_div && (val2 == '0)) begin
                     dbz_d   = 1'b1;
                     acc_d   = {{WORD_LEN{1'b0}}, val1};
                     state_d = MD_FIX;
                  end else begin
                     dbz_d   = 1'b0;
                     acc_d   = {{WORD_LEN{1'b0}}, abs1};
                     state_d = MD_RUN;
                  end
               end
            end
            MD_RUN: begin
               if (div_q) begin
                  if (!div_diff[WORD_LEN+1]) begin
                     rem_d = div_diff[WORD_LEN:0];
                     acc_d = {acc_q[2*WORD_LEN-1:WORD_LEN], acc_q[WORD_LEN-2:0], 1'b1};
                  end else begin
                     rem_d = div_shift;
                     acc_d = {acc_q[2*WORD_LEN-1:WORD_LEN], acc_q[WORD_LEN-2:0], 1'b0};
                  end
               end else begin
                  acc_d = {mul_sum, acc_q[WORD_LEN-1:1]};
               end
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = MD_FIX;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            MD_FIX: begin
               if (dbz_q) begin
                  hi_d = acc_q[WORD_LEN-1:0];
                  lo_d = '1;
               end else begin
                  hi_d = adj_hi;
                  lo_d = adj_lo;
               end
               done_d    = 1'b1;
               dbz_out_d = dbz_q;
               state_d   = MD_IDLE;
            end
            default: state_d = MD_IDLE;
         endcase
      end
   end

   assign busy        = (state_q != MD_IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_out_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, results, divide-by-zero, flush, reset, start rules.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  md_op;
   logic [31:0] val1, val2;
   logic        flush;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int n_checks = 0;
   int n_errors = 0;

   mul_div_unit #(.WORD_LEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .md_op       (md_op),
      .val1        (val1),
      .val2        (val2),
      .flush       (flush),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Starts an op in the current cycle, optionally re-pokes start at cycle lat==poke,
   // and checks latency, busy shape and the result in the done cycle (left there on return).
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] eh,
                         input logic [31:0] el, input logic edbz, input int poke);
      int   lat;
      logic busy_ok;
      busy_ok = 1'b1;
      start = 1'b1; md_op = op; val1 = a; val2 = b;
      tick();
      start = 1'b0; md_op = ~op; val1 = 32'hDEAD_BEEF; val2 = 32'h1234_5678;
      lat = 1;
      while (done !== 1'b1 && lat < 60) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (lat == poke) begin
            start = 1'b1; md_op = MD_MULTU; val1 = '1; val2 = '1;
         end else begin
            start = 1'b0;
         end
         tick();
         lat++;
      end
      start = 1'b0;
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " busy during op"}, 32'(busy_ok), 32'd1);
      chk({tag, " busy at done"}, 32'(busy), 32'd0);
      chk({tag, " hi"}, hi, eh);
      chk({tag, " lo"}, lo, el);
      chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edbz));
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; md_op = MD_MULTU; val1 = '0; val2 = '0; flush = 1'b0;
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      tick(); tick();
      rst = 1'b1;
      tick();

      run_op("MULTU max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
      // Start in the done cycle is accepted.
      run_op("MULT -3*5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
      tick();
      chk("done pulse width", 32'(done), 32'd0);
      chk("hi hold", hi, 32'hFFFF_FFFF);
      chk("lo hold", lo, 32'hFFFF_FFF1);

      run_op("DIV -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
      tick();
      run_op("DIV 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 34, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0);
      tick();
      run_op("DIV min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000, 1'b0, 0);
      tick();
      run_op("MULT min*min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 32'h0000_0000, 1'b0, 0);
      tick();
      run_op("DIVU 100/7", MD_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 0);
      tick();
      run_op("DIVU 7/0", MD_DIVU, 32'd7, 32'd0, 2, 32'd7, 32'hFFFF_FFFF, 1'b1, 0);
      tick();
      chk("dbz pulse width", 32'(div_by_zero), 32'd0);
      chk("dbz done width", 32'(done), 32'd0);
      run_op("DIV -5/0", MD_DIV, 32'hFFFF_FFFB, 32'd0, 2, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 0);
      tick();

      // Flush in N+10 of a MULTU.
      start = 1'b1; md_op = MD_MULTU; val1 = 32'd9; val2 = 32'd9;
      tick();
      start = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush busy", 32'(busy), 32'd0);
      chk("flush done", 32'(done), 32'd0);
      chk("flush hi kept", hi, 32'hFFFF_FFFB);
      chk("flush lo kept", lo, 32'hFFFF_FFFF);
      tick();
      chk("flush no late done", 32'(done), 32'd0);
      run_op("MULTU after flush", MD_MULTU, 32'd3, 32'd4, 34, 32'd0, 32'd12, 1'b0, 0);
      tick();

      // Flush in IDLE blocks a coincident start.
      start = 1'b1; flush = 1'b1; md_op = MD_MULTU; val1 = 32'd5; val2 = 32'd5;
      tick();
      start = 1'b0; flush = 1'b0;
      chk("idle flush blocks start", 32'(busy), 32'd0);

      // Asynchronous reset in N+5 of a DIVU.
      start = 1'b1; md_op = MD_DIVU; val1 = 32'd100; val2 = 32'd7;
      tick();
      start = 1'b0;
      repeat (4) tick();
      #2 rst = 1'b0;
      #1;
      chk("async rst busy", 32'(busy), 32'd0);
      chk("async rst hi", hi, 32'd0);
      chk("async rst lo", lo, 32'd0);
      tick();
      rst = 1'b1;
      tick();
      chk("post rst done", 32'(done), 32'd0);

      // Start while busy is ignored; start in the done cycle is accepted.
      run_op("DIVU ignore busy start", MD_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 5);
      run_op("MULTU back-to-back", MD_MULTU, 32'd6, 32'd7, 34, 32'd0, 32'd42, 1'b0, 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
